regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between EX and MEM sources.
// Round-robin by default; define WB_ARB_FIXED_PRIO_EN to make MEM always win a tie.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  logic [ADDR_W-1:0] i_ex_waddr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_waddr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // state   | meaning
    // GNT_EX  | EX received the most recent grant; MEM wins the next tie
    // GNT_MEM | MEM received the most recent grant (reset); EX wins the next tie
    typedef enum logic {
        GNT_EX  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    logic              w_gnt_ex;
    logic              w_gnt_mem;
    logic              w_grant;
    logic              w_wr;
    logic              w_refused;
    logic [ADDR_W-1:0] w_sel_waddr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [CNT_W-1:0]  r_stall_cnt;

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        w_gnt_mem = rst && i_mem_valid;
        w_gnt_ex  = rst && i_ex_valid && !i_mem_valid;
    end
`else
    gnt_t r_last_gnt;
    gnt_t w_last_gnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst) r_last_gnt <= GNT_MEM;
        else      r_last_gnt <= w_last_gnt_nxt;
    end

    always_comb begin
        w_gnt_ex       = 1'b0;
        w_gnt_mem      = 1'b0;
        w_last_gnt_nxt = r_last_gnt;
        if (rst) begin
            if (i_ex_valid && i_mem_valid) begin
                if (r_last_gnt == GNT_MEM) w_gnt_ex  = 1'b1;
                else                       w_gnt_mem = 1'b1;
            end else if (i_ex_valid) begin
                w_gnt_ex = 1'b1;
            end else if (i_mem_valid) begin
                w_gnt_mem = 1'b1;
            end
            if (w_gnt_ex)       w_last_gnt_nxt = GNT_EX;
            else if (w_gnt_mem) w_last_gnt_nxt = GNT_MEM;
        end
    end
`endif

    always_comb begin
        w_grant     = w_gnt_ex || w_gnt_mem;
        w_sel_waddr = w_gnt_mem ? i_mem_waddr : i_ex_waddr;
        w_sel_wdata = w_gnt_mem ? i_mem_wdata : i_ex_wdata;
        // x0 writes are handshaken but never reach the register file
        w_wr        = w_grant && (w_sel_waddr != '0);
        w_refused   = rst && ((i_ex_valid && !w_gnt_ex) || (i_mem_valid && !w_gnt_mem));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_rf_we <= w_wr;
            if (w_wr) begin
                r_rf_waddr <= w_sel_waddr;
                r_rf_wdata <= w_sel_wdata;
            end
            if (w_refused && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Gating with rst drops a write that was registered just before reset arrived
    assign o_rf_we     = r_rf_we && rst;
    assign o_rf_waddr  = r_rf_waddr;
    assign o_rf_wdata  = r_rf_wdata;
    assign o_stall_cnt = r_stall_cnt;
    assign o_ex_ready  = w_gnt_ex;
    assign o_mem_ready = w_gnt_mem;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued when a cycle
// is driven and popped when the registered write appears one cycle later.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        i_ex_valid;
    logic [4:0]  i_ex_waddr;
    logic [31:0] i_ex_wdata;
    logic        i_mem_valid;
    logic [4:0]  i_mem_waddr;
    logic [31:0] i_mem_wdata;

    logic        o_ex_ready,  s_ex_ready;
    logic        o_mem_ready, s_mem_ready;
    logic        o_rf_we,     s_rf_we;
    logic [4:0]  o_rf_waddr,  s_rf_waddr;
    logic [31:0] o_rf_wdata,  s_rf_wdata;
    logic [15:0] o_stall_cnt;
    logic [1:0]  s_stall_cnt;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready),
        .i_ex_waddr(i_ex_waddr), .i_ex_wdata(i_ex_wdata),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .i_mem_waddr(i_mem_waddr), .i_mem_wdata(i_mem_wdata),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_stall_cnt(o_stall_cnt)
    );

    regfile_wb_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .i_ex_valid(i_ex_valid), .o_ex_ready(s_ex_ready),
        .i_ex_waddr(i_ex_waddr), .i_ex_wdata(i_ex_wdata),
        .i_mem_valid(i_mem_valid), .o_mem_ready(s_mem_ready),
        .i_mem_waddr(i_mem_waddr), .i_mem_wdata(i_mem_wdata),
        .o_rf_we(s_rf_we), .o_rf_waddr(s_rf_waddr), .o_rf_wdata(s_rf_wdata),
        .o_stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        m_last;   // 1: MEM granted last
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_stall;
    int          m_sat;
    logic        last_gex, last_gmem;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r,
                        input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        exp_t        e;
        exp_t        n;
        logic        gex, gmem;
        logic [4:0]  a;
        rst = r;
        i_ex_valid = ev;  i_ex_waddr = ea;  i_ex_wdata = ed;
        i_mem_valid = mv; i_mem_waddr = ma; i_mem_wdata = md;
        @(negedge clk);
        if (q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk("rf_we", {31'd0, o_rf_we}, {31'd0, e.we && r});
            chk("rf_waddr", {27'd0, o_rf_waddr}, {27'd0, e.waddr});
            chk("rf_wdata", o_rf_wdata, e.wdata);
        end
        chk("stall_cnt", {16'd0, o_stall_cnt}, m_stall);
        chk("stall_cnt_sat", {30'd0, s_stall_cnt}, m_sat);

        gex = 1'b0;
        gmem = 1'b0;
        if (r) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            gmem = mv;
            gex  = ev && !mv;
`else
            if (ev && mv) begin
                gex  = m_last;
                gmem = !m_last;
            end else begin
                gex  = ev;
                gmem = mv;
            end
`endif
        end
        chk("ex_ready", {31'd0, o_ex_ready}, {31'd0, gex});
        chk("mem_ready", {31'd0, o_mem_ready}, {31'd0, gmem});

        n.we = 1'b0;
        if (!r) begin
            m_last = 1'b1; m_waddr = '0; m_wdata = '0; m_stall = 0; m_sat = 0;
        end else begin
            if ((ev && !gex) || (mv && !gmem)) begin
                if (m_stall < 65535) m_stall++;
                if (m_sat < 3) m_sat++;
            end
            if (gex || gmem) begin
                m_last = gmem;
                a = gmem ? ma : ea;
                if (a != 5'd0) begin
                    n.we = 1'b1;
                    m_waddr = a;
                    m_wdata = gmem ? md : ed;
                end
            end
        end
        n.waddr = m_waddr;
        n.wdata = m_wdata;
        q.push_back(n);
        last_gex = gex;
        last_gmem = gmem;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    logic        pe_v, pm_v;
    logic [4:0]  pe_a, pm_a;
    logic [31:0] pe_d, pm_d;

    initial begin
        rst = 1'b0;
        i_ex_valid = 1'b0;  i_ex_waddr = '0;  i_ex_wdata = '0;
        i_mem_valid = 1'b0; i_mem_waddr = '0; i_mem_wdata = '0;
        m_last = 1'b1; m_waddr = '0; m_wdata = '0; m_stall = 0; m_sat = 0;
        q.push_back('{1'b0, 5'd0, 32'd0});
        @(posedge clk);
        #1;

        // reset with EX requesting: no ready, no write
        repeat (2) step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);

        // tie for 4 cycles: EX, MEM, EX, MEM
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 5'(10 + i), 32'hE000_0000 + i, 1'b1, 5'(20 + i), 32'hA000_0000 + i);
        idle();
        idle();

        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle();
        idle();

        // x0 load consumed; next tie goes to EX
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_AAAA);
        step(1'b1, 1'b1, 5'd7, 32'h7777, 1'b1, 5'd8, 32'h8888);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888);

        // same destination from both sources
        step(1'b1, 1'b1, 5'd9, 32'h9E9E, 1'b1, 5'd9, 32'h9A9A);
        if (last_gex) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9A9A);
        else          step(1'b1, 1'b1, 5'd9, 32'h9E9E, 1'b0, 5'd0, 32'd0);
        idle();

        // random traffic, payloads held until accepted
        pe_v = 1'b0; pm_v = 1'b0; pe_a = '0; pm_a = '0; pe_d = '0; pm_d = '0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, pe_v, pe_a, pe_d, pm_v, pm_a, pm_d);
            if (last_gex || !pe_v) begin
                pe_v = ($urandom_range(0, 3) != 0);
                pe_a = 5'($urandom_range(0, 31));
                pe_d = $urandom;
            end
            if (last_gmem || !pm_v) begin
                pm_v = ($urandom_range(0, 3) != 0);
                pm_a = 5'($urandom_range(0, 31));
                pm_d = $urandom;
            end
        end
        idle();

        // grant then reset: write dropped
        step(1'b1, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle();

        // constant conflict: narrow counter saturates at 3
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 5'(1 + i), 32'hC0 + i, 1'b1, 5'(16 + i), 32'hD0 + i);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
